// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry defaults and the slave/master FSM encoding.
package spi_pkg;

  localparam int SPI_CMD_WIDTH  = 12;
  localparam int SPI_READ_WIDTH = 8;
  localparam int SPI_ADDR_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus a third flop and
// registered rise/fall pulses; dly_o is the level aligned with the pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync_o,
  output logic dly_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic rise_q, fall_q;
  logic rise_d, fall_d;

  // Edge decode between the synchronized level and its one-cycle-old copy
  always_comb begin
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // Synchronizer chain and edge pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      s3_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_o = s2_q;
  assign dly_o  = s3_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 register slave: rw/addr header, then write data in or read data out,
// with a 2**ADDR_WIDTH register file also loadable from the host side.
module spi_slave
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH  = SPI_CMD_WIDTH,
  parameter int READ_WIDTH = SPI_READ_WIDTH,
  parameter int ADDR_WIDTH = SPI_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [READ_WIDTH-1:0] ld_data,
  output logic                  wr_vld,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [READ_WIDTH-1:0] wr_data,
  output logic                  read_vld,
  output logic [READ_WIDTH-1:0] read_data
);

  localparam int CNT_W  = $clog2(CMD_WIDTH + 1);
  localparam int NREGS  = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(READ_WIDTH - 1);

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, cs_sync_s, mosi_s;
  logic sclk_sync_unused, sclk_dly_unused, cs_dly_unused;
  logic mosi_sync_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .sync_o(sclk_sync_unused), .dly_o(sclk_dly_unused),
    .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs),
    .sync_o(cs_sync_s), .dly_o(cs_dly_unused),
    .rise_o(cs_rise_s), .fall_o(cs_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .sync_o(mosi_sync_unused), .dly_o(mosi_s),
    .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  spi_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]     hdr_q, hdr_d, hdr_nxt_s;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [READ_WIDTH-1:0]   data_q, data_d, data_nxt_s;
  logic [READ_WIDTH-1:0]   shift_q, shift_d;
  logic [READ_WIDTH-1:0]   rdload_q, rdload_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic                    wr_vld_q, wr_vld_d, read_vld_q, read_vld_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [READ_WIDTH-1:0]   wr_data_q, wr_data_d, read_data_q, read_data_d;
  logic [READ_WIDTH-1:0]   regs_q [NREGS];
  logic [READ_WIDTH-1:0]   regs_d [NREGS];

  // Frame sequencing: header collection, data phase, abort on early cs rise
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    shift_d     = shift_q;
    rdload_d    = rdload_q;
    wr_pend_d   = 1'b0;
    read_vld_d  = 1'b0;
    read_data_d = read_data_q;
    hdr_nxt_s   = {hdr_q[ADDR_WIDTH-1:0], mosi_s};
    data_nxt_s  = {data_q[READ_WIDTH-2:0], mosi_s};
    case (state_q)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_d = ST_HDR;
          cnt_d   = {CNT_W{1'b0}};
          hdr_d   = {(ADDR_WIDTH+1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          hdr_d = hdr_nxt_s;
          if (cnt_q == HDR_LAST) begin
            cnt_d  = {CNT_W{1'b0}};
            addr_d = hdr_nxt_s[ADDR_WIDTH-1:0];
            if (hdr_nxt_s[ADDR_WIDTH]) begin
              state_d  = ST_RDATA;
              shift_d  = regs_q[hdr_nxt_s[ADDR_WIDTH-1:0]];
              rdload_d = regs_q[hdr_nxt_s[ADDR_WIDTH-1:0]];
            end else begin
              state_d = ST_WDATA;
            end
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_WDATA: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          data_d = data_nxt_s;
          if (cnt_q == DATA_LAST) begin
            state_d   = ST_DONE;
            wr_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_RDATA: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise_s) begin
          if (cnt_q == DATA_LAST) begin
            state_d     = ST_DONE;
            read_vld_d  = 1'b1;
            read_data_d = rdload_q;
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (sclk_fall_s && (cnt_q != {CNT_W{1'b0}})) begin
          // The fall right after the header must keep the MSB on the line
          shift_d = {shift_q[READ_WIDTH-2:0], 1'b0};
        end else begin
          state_d = ST_RDATA;
        end
      end
      ST_DONE: begin
        if (cs_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write commit stage, registered serial outputs, register file update
  always_comb begin
    wr_vld_d  = wr_pend_q;
    wr_addr_d = wr_pend_q ? addr_q : wr_addr_q;
    wr_data_d = wr_pend_q ? data_q : wr_data_q;
    miso_oe_d = (state_d == ST_RDATA) && !cs_sync_s;
    miso_d    = (state_d == ST_RDATA) ? shift_d[READ_WIDTH-1] : 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (wr_pend_q && (addr_q == ADDR_WIDTH'(i))) ? data_q :
                  (ld_en && (ld_addr == ADDR_WIDTH'(i)))    ? ld_data :
                                                              regs_q[i];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      hdr_q       <= {(ADDR_WIDTH+1){1'b0}};
      addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q      <= {READ_WIDTH{1'b0}};
      shift_q     <= {READ_WIDTH{1'b0}};
      rdload_q    <= {READ_WIDTH{1'b0}};
      wr_pend_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_vld_q    <= 1'b0;
      wr_addr_q   <= {ADDR_WIDTH{1'b0}};
      wr_data_q   <= {READ_WIDTH{1'b0}};
      read_vld_q  <= 1'b0;
      read_data_q <= {READ_WIDTH{1'b0}};
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {READ_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      rdload_q    <= rdload_d;
      wr_pend_q   <= wr_pend_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_vld_q    <= wr_vld_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      read_vld_q  <= read_vld_d;
      read_data_q <= read_data_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_vld    = wr_vld_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign read_vld  = read_vld_q;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed vector table, corner sequences and
// random frames checked against a frame-level register model.
module tb_spi_slave;

  localparam int AW   = 3;
  localparam int RW   = 8;
  localparam int CW   = 12;
  localparam int HALF = 6;

  logic          clk = 1'b0;
  logic          rst, sclk, cs, mosi, miso, miso_oe, ld_en;
  logic [AW-1:0] ld_addr, wr_addr;
  logic [RW-1:0] ld_data, wr_data, read_data;
  logic          wr_vld, read_vld;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  logic [RW-1:0] last_rd = 8'h00;
  logic [RW-1:0] ref_regs [8];

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    int            nbits;
    int            ld_mode;   // 0 none, 1 load before frame, 2 load on the commit edge
    logic [AW-1:0] ld_addr;
    logic [RW-1:0] ld_data;
    int            exp_wr;
    int            exp_rd;
    logic [RW-1:0] exp_val;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  spi_slave #(.CMD_WIDTH(CW), .READ_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .read_vld(read_vld), .read_data(read_data)
  );

  always @(negedge clk) begin
    if (wr_vld) wr_cnt++;
    if (read_vld) begin
      rd_cnt++;
      last_rd = read_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_reg(input logic [AW-1:0] a, input logic [RW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick(1);
    ld_en = 1'b0;
    ref_regs[a] = d;
  endtask

  task automatic spi_pulse(input logic b);
    mosi = b; tick(HALF);
    sclk = 1'b1; tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, output int n_wr, output int n_rd,
                           output logic [RW-1:0] miso_bits, output logic [15:0] oe_mask,
                           output int wr_k);
    logic [CW-1:0] cmd;
    int w0, r0;
    cmd = {v.rw, v.addr, v.data};
    w0 = wr_cnt; r0 = rd_cnt;
    miso_bits = 8'h00; oe_mask = 16'h0000; wr_k = 0;
    cs = 1'b0; tick(HALF);
    for (int i = 0; i < v.nbits; i++) begin
      mosi = (i < CW) ? cmd[CW-1-i] : 1'($urandom_range(0, 1));
      tick(HALF);
      oe_mask[i] = miso_oe;
      if (i >= 1 + AW && i < CW) miso_bits[CW-1-i] = miso;
      sclk = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (i == CW - 1 && wr_k == 0 && wr_vld) wr_k = k;
        if (i == CW - 1 && v.ld_mode == 2 && k == 4) begin
          ld_en = 1'b1; ld_addr = v.ld_addr; ld_data = v.ld_data;
        end
        if (i == CW - 1 && v.ld_mode == 2 && k == 5) ld_en = 1'b0;
      end
      sclk = 1'b0;
    end
    tick(HALF);
    cs = 1'b1;
    tick(HALF + 4);
    oe_mask[15] = miso_oe;
    n_wr = wr_cnt - w0;
    n_rd = rd_cnt - r0;
  endtask

  // Frame-level model: a complete write stores data, a complete read returns the
  // stored value, anything shorter has no effect; drive enable covers read data bits.
  task automatic check_frame(input string tag, input vec_t v, input logic from_table);
    int m_wr, m_rd, n_wr, n_rd, wr_k;
    logic [RW-1:0] m_val, miso_bits;
    logic [15:0]   m_oe, oe_mask;
    if (v.ld_mode == 1) load_reg(v.ld_addr, v.ld_data);
    m_oe = 16'h0000;
    if (v.rw) for (int i = 1 + AW; i < v.nbits && i < CW; i++) m_oe[i] = 1'b1;
    m_wr = 0; m_rd = 0; m_val = 8'h00;
    if (v.nbits >= CW && v.rw) begin
      m_rd = 1; m_val = ref_regs[v.addr];
    end else if (v.nbits >= CW) begin
      m_wr = 1; m_val = v.data;
      if (v.ld_mode == 2) ref_regs[v.ld_addr] = v.ld_data;
      ref_regs[v.addr] = v.data;
    end
    if (from_table) begin
      m_wr = v.exp_wr; m_rd = v.exp_rd; m_val = v.exp_val;
    end
    run_frame(v, n_wr, n_rd, miso_bits, oe_mask, wr_k);
    check({tag, "_wr_count"}, n_wr, m_wr);
    check({tag, "_rd_count"}, n_rd, m_rd);
    check({tag, "_miso_oe"}, oe_mask, m_oe);
    if (m_wr == 1) begin
      check({tag, "_wr_addr"}, wr_addr, v.addr);
      check({tag, "_wr_data"}, wr_data, m_val);
      check({tag, "_wr_latency"}, wr_k, 5);
    end
    if (m_rd == 1) begin
      check({tag, "_read_data"}, last_rd, m_val);
      check({tag, "_miso_bits"}, miso_bits, m_val);
    end
  endtask

  initial begin
    int r0;
    vec_t rv;

    //        rw    addr  data   n   ld  ldaddr ldata  wr rd val
    vecs[0]  = '{1'b0, 3'd5, 8'hA7, 12, 0, 3'd0, 8'h00, 1, 0, 8'hA7};
    vecs[1]  = '{1'b1, 3'd5, 8'h00, 12, 0, 3'd0, 8'h00, 0, 1, 8'hA7};
    vecs[2]  = '{1'b1, 3'd2, 8'h00, 12, 1, 3'd2, 8'h3C, 0, 1, 8'h3C};
    vecs[3]  = '{1'b0, 3'd1, 8'h55, 12, 0, 3'd0, 8'h00, 1, 0, 8'h55};
    vecs[4]  = '{1'b0, 3'd1, 8'hAA,  7, 0, 3'd0, 8'h00, 0, 0, 8'h00};
    vecs[5]  = '{1'b1, 3'd1, 8'h00, 12, 0, 3'd0, 8'h00, 0, 1, 8'h55};
    vecs[6]  = '{1'b0, 3'd1, 8'hAA, 12, 0, 3'd0, 8'h00, 1, 0, 8'hAA};
    vecs[7]  = '{1'b0, 3'd0, 8'hFF, 14, 0, 3'd0, 8'h00, 1, 0, 8'hFF};
    vecs[8]  = '{1'b1, 3'd0, 8'h00, 12, 0, 3'd0, 8'h00, 0, 1, 8'hFF};
    vecs[9]  = '{1'b0, 3'd4, 8'h22, 12, 2, 3'd4, 8'h11, 1, 0, 8'h22};
    vecs[10] = '{1'b1, 3'd4, 8'h00, 12, 0, 3'd0, 8'h00, 0, 1, 8'h22};
    vecs[11] = '{1'b1, 3'd7, 8'h00, 12, 0, 3'd0, 8'h00, 0, 1, 8'h00};
    vecs[12] = '{1'b1, 3'd3, 8'h00, 14, 0, 3'd0, 8'h00, 0, 1, 8'h00};

    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    ld_en = 1'b0; ld_addr = 3'd0; ld_data = 8'h00;
    for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    tick(3);
    check("reset_outputs", {miso, miso_oe, wr_vld, wr_addr, wr_data, read_vld, read_data}, 32'h0);
    rst = 1'b0;
    tick(4);
    check("idle_outputs", {miso, miso_oe, wr_vld, wr_addr, wr_data, read_vld, read_data}, 32'h0);

    for (int i = 0; i < 13; i++) check_frame($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Reset in the middle of a read of addr 6
    load_reg(3'd6, 8'h5A);
    cs = 1'b0; tick(HALF);
    spi_pulse(1'b1); spi_pulse(1'b1); spi_pulse(1'b1); spi_pulse(1'b0);
    spi_pulse(1'b0); spi_pulse(1'b1); spi_pulse(1'b0);
    tick(2);
    check("oe_before_rst", miso_oe, 1'b1);
    r0 = rd_cnt;
    rst = 1'b1;
    #1;
    check("oe_at_rst", miso_oe, 1'b0);
    tick(3);
    cs = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    tick(HALF);
    check("rst_no_read_vld", rd_cnt - r0, 0);
    rv = '{1'b1, 3'd6, 8'h00, 12, 0, 3'd0, 8'h00, 0, 0, 8'h00};
    check_frame("post_rst_read_cleared", rv, 1'b0);
    rv = '{1'b1, 3'd6, 8'h00, 12, 1, 3'd6, 8'h5A, 0, 0, 8'h00};
    check_frame("post_rst_read_loaded", rv, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int sel;
      rv.rw    = 1'($urandom_range(0, 1));
      rv.addr  = 3'($urandom_range(0, 7));
      rv.data  = 8'($urandom_range(0, 255));
      sel      = $urandom_range(0, 5);
      rv.nbits = (sel == 0) ? $urandom_range(2, 11) : (sel == 5) ? $urandom_range(13, 15) : 12;
      rv.ld_addr = 3'($urandom_range(0, 7));
      rv.ld_data = 8'($urandom_range(0, 255));
      if (!rv.rw && rv.nbits >= CW && $urandom_range(0, 2) == 0) rv.ld_mode = 2;
      else if ($urandom_range(0, 2) == 0) rv.ld_mode = 1;
      else rv.ld_mode = 0;
      rv.exp_wr = 0; rv.exp_rd = 0; rv.exp_val = 8'h00;
      check_frame($sformatf("rand%0d", n), rv, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter CMD_WIDTH, default 12, SHALL be the frame length in bits: 1 rw + ADDR_WIDTH addr + READ_WIDTH data.
REQ-002 Parameter READ_WIDTH, default 8, SHALL be the register/data width.
REQ-003 Parameter ADDR_WIDTH, default 3, SHALL give 2**ADDR_WIDTH internal registers.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset; ports SHALL be as listed in REQ-005 to REQ-017.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 sclk  in  1  SPI clock from master, asynchronous, idle low.
REQ-008 cs  in  1  chip select, active low, asynchronous.
REQ-009 mosi  in  1  serial data from master.
REQ-010 miso  out  1  serial data to master.
REQ-011 miso_oe  out  1  miso drive enable, high only during read data phase.
REQ-012 ld_en  in  1  host register load strobe.
REQ-013 ld_addr  in  ADDR_WIDTH  host load address.
REQ-014 ld_data  in  READ_WIDTH  host load data.
REQ-015 wr_vld  out  1  one-cycle pulse, SPI write committed.
REQ-016 wr_addr / wr_data  out  ADDR_WIDTH / READ_WIDTH  address/data of last SPI write, held until next write.
REQ-017 read_vld / read_data  out  1 / READ_WIDTH  one-cycle pulse plus value shifted out on a completed SPI read.

Function
REQ-018 sclk, cs, mosi SHALL each pass a 2-flop synchronizer; a third flop on sclk and cs SHALL provide rise/fall edge detection.
REQ-019 SPI mode 0: mosi sampled on detected sclk rise, miso updated on detected sclk fall, MSB first.
REQ-020 Frame: bit 0 rw (1 = read), next ADDR_WIDTH bits address, last READ_WIDTH bits data.
REQ-021 FSM states: IDLE, HDR, WDATA, RDATA, DONE.
REQ-022 IDLE -> HDR on detected cs fall; bit counter cleared.
REQ-023 HDR: after 1+ADDR_WIDTH rises -> WDATA if rw=0, else -> RDATA with shift register loaded from reg[addr] on the same cycle.
REQ-024 RDATA: miso_oe=1; miso = shift MSB; shift left on each sclk fall; after READ_WIDTH rises -> DONE, read_vld pulses with read_data = loaded value.
REQ-025 WDATA: after READ_WIDTH rises -> DONE; reg[addr] written; wr_vld pulses one cycle with wr_addr/wr_data.
REQ-026 DONE: further sclk edges ignored; -> IDLE on detected cs rise.
REQ-027 cs rise in HDR/WDATA/RDATA SHALL abort: no register write, no wr_vld/read_vld, -> IDLE.
REQ-028 wr_vld SHALL assert 4 clk after the clk edge that first samples the final sclk rise high.
REQ-029 ld_en SHALL write reg[ld_addr] next clk edge; same-cycle SPI write to same address wins.
REQ-030 Correct operation requires sclk high and low times each >= 4 clk periods.
REQ-031 miso_oe SHALL be 0 whenever synchronized cs is high.

Reset
REQ-032 On rst: state IDLE; counters, shift register, all registers 0; miso, miso_oe, wr_vld, wr_addr, wr_data, read_vld, read_data 0; sclk sync flops 0, cs sync flops 1.
REQ-033 rst mid-frame SHALL discard the frame; after release the block waits for a fresh cs fall.

Structure
REQ-034 State encoding and default widths SHALL live in shared package spi_pkg, also used by the SPI master.
REQ-035 Synchronizer plus edge detect SHALL be sub-module spi_sync_edge, instantiated per sampled input.

Verification
REQ-036 Write frame rw=0, addr=5, data=0xA7 -> one wr_vld, wr_addr=5, wr_data=0xA7, reg[5]=0xA7.
REQ-037 ld_en addr=2 data=0x3C, then read frame addr=2 -> miso bits 0,0,1,1,1,1,0,0; read_vld with read_data=0x3C.
REQ-038 cs rise after 7 bits of write to addr=1 -> no wr_vld, reg[1] unchanged, next full frame succeeds.
REQ-039 ld_en addr=4 data=0x11 on the cycle SPI write addr=4 data=0x22 commits -> reg[4]=0x22.
REQ-040 14 sclk pulses in one cs window with write to addr=0 data=0xFF -> exactly one wr_vld, extra bits ignored.
REQ-041 rst asserted mid-read -> miso_oe=0 immediately, no read_vld, subsequent read returns correct data.
